einstein_irq_ctrl: RTL and testbench

- Interrupt scheduler for the non-CTC Z80 mode-2 sources: keyboard, ADC and fire button.
- Latches source edges, applies per-source masks and fixed priority, and drives a registered INT_n to the T80.
- Supplies the mode-2 vector during interrupt acknowledge and tracks in-service state until RETI.
- Heads the Z80 daisy chain: its ieo feeds the CTC IEI, so these sources outrank the CTC.

---
 rtl/tatung_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 41 ++++
 rtl/einstein_irq_ctrl.sv | 157 +++++++++++++++
 tb/tb_einstein_irq_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tatung_pkg.sv
// Shared definitions for the Tatung Einstein interrupt logic.
//   INTVEC_*  : Z80 mode-2 vectors for the non-CTC interrupt sources
//   SRC_*     : source indices; a lower index means a higher priority
//   irq_state_t : acknowledge state machine states of einstein_irq_ctrl
package tatung_pkg;

    localparam logic [7:0] INTVEC_KB   = 8'h0E;
    localparam logic [7:0] INTVEC_ADC  = 8'h0A;
    localparam logic [7:0] INTVEC_FIRE = 8'h0C;

    localparam int SRC_KB   = 0;
    localparam int SRC_ADC  = 1;
    localparam int SRC_FIRE = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder (index 0 = highest priority).
//   req_i     : eligible requests
//   lsb_i     : in-service flags
//   idx_o     : index of the lowest set bit of req_i (0 when none)
//   valid_o   : any bit of req_i set
//   lsb_sel_o : one-hot of the lowest set bit of lsb_i (all zero when none)
module irq_prio_enc #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  lsb_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o,
    output logic [N-1:0]  lsb_sel_o
);

    // Scan from the lowest priority upward so the highest-priority hit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lsb
            if (gi == 0) begin : g_first
                assign lsb_sel_o[gi] = lsb_i[gi];
            end else begin : g_rest
                assign lsb_sel_o[gi] = lsb_i[gi] & ~(|lsb_i[gi-1:0]);
            end
        end
    endgenerate

endmodule

// File: rtl/einstein_irq_ctrl.sv
// Z80 mode-2 interrupt controller for keyboard, ADC and fire button.
// Heads the daisy chain ahead of the CTC.
//   clk_sys, reset_n     : clock, asynchronous active-low reset
//   m1_n, iorq_n         : CPU cycle strobes (both low = interrupt acknowledge)
//   reti                 : one-cycle RETI decode pulse
//   iei / ieo            : daisy-chain enable in / out
//   src                  : source levels, rising edge requests an interrupt
//   mask_we, mask_din    : per-source mask write (1 = masked)
//   clr                  : per-source pending clear
//   int_n                : registered interrupt request to the CPU
//   vec, vec_oe          : mode-2 vector and its bus drive enable
//   pending, in_service, mask : status
module einstein_irq_ctrl
    import tatung_pkg::*;
#(
    parameter int             NSRC     = 3,
    parameter logic [7:0]     VEC0     = INTVEC_KB,
    parameter logic [7:0]     VEC1     = INTVEC_ADC,
    parameter logic [7:0]     VEC2     = INTVEC_FIRE,
    parameter logic [NSRC-1:0] MASK_RST = {NSRC{1'b1}}
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            m1_n,
    input  logic            iorq_n,
    input  logic            reti,
    input  logic            iei,
    input  logic [NSRC-1:0] src,
    input  logic [NSRC-1:0] mask_we,
    input  logic            mask_din,
    input  logic [NSRC-1:0] clr,
    output logic            int_n,
    output logic [7:0]      vec,
    output logic            vec_oe,
    output logic            ieo,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service,
    output logic [NSRC-1:0] mask
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    irq_state_t      state_q, state_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] in_service_q, in_service_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            int_n_q, int_n_d;
    logic [7:0]      vec_q, vec_d;

    logic            intack;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] blocked;
    logic [NSRC-1:0] eligible;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic [NSRC-1:0] win_sel;
    logic [NSRC-1:0] reti_sel;
    logic            ack_entry;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] reti_clr;

    assign intack = ~m1_n & ~iorq_n;
    assign rise   = src & ~src_q;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            // A source is held off by its own or any higher-priority
            // service; lower-priority services do not block it (nesting).
            assign blocked[gi]  = |in_service_q[gi:0];
            assign eligible[gi] = pending_q[gi] & ~mask_q[gi] & ~blocked[gi];
            assign win_sel[gi]  = win_valid & (win_idx == IW'(gi));
        end
    endgenerate

    irq_prio_enc #(
        .N(NSRC)
    ) u_prio (
        .req_i     (eligible),
        .lsb_i     (in_service_q),
        .idx_o     (win_idx),
        .valid_o   (win_valid),
        .lsb_sel_o (reti_sel)
    );

    // Acknowledge only while heading the chain with a live winner; an
    // intack seen anywhere else belongs to the CTC.
    assign ack_entry = (state_q == REQ) & intack & iei & win_valid;
    assign ack_clr   = ack_entry ? win_sel : '0;
    assign reti_clr  = (reti & iei) ? reti_sel : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!int_n_q) state_d = REQ;
            REQ: begin
                if (ack_entry)       state_d = ACK;
                else if (!win_valid) state_d = IDLE;
            end
            ACK:  if (!intack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mask_we[i]) mask_d[i] = mask_din;
        end
        // Clears first, then a fresh edge overrides them (set wins).
        pending_d = pending_q & ~clr & ~ack_clr & ~(mask_we & {NSRC{mask_din}});
        pending_d = pending_d | (rise & ~mask_q);
        // The winner never has an in-service bit at or above its own
        // priority, so the RETI clear cannot hit the bit being set here.
        in_service_d = (in_service_q & ~reti_clr) | ack_clr;
        // Request is frozen through any M1 so it cannot change mid-cycle.
        int_n_d = m1_n ? ~(iei & win_valid) : int_n_q;
        vec_d   = vec_q;
        if (ack_entry) begin
            if (win_idx == IW'(0))      vec_d = VEC0;
            else if (win_idx == IW'(1)) vec_d = VEC1;
            else                        vec_d = VEC2;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= MASK_RST;
            int_n_q      <= 1'b1;
            vec_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            src_q        <= src;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            int_n_q      <= int_n_d;
            vec_q        <= vec_d;
        end
    end

    assign int_n      = int_n_q;
    assign vec        = vec_q;
    // Combinational on intack so the bus is released in the same cycle the
    // CPU lets go, and immediately on an asynchronous reset.
    assign vec_oe     = (state_q == ACK) & intack;
    assign ieo        = iei & ~(|in_service_q) & int_n_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_einstein_irq_ctrl.sv
module tb_einstein_irq_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       m1_n, iorq_n, reti, iei, mask_din;
    logic [2:0] src, mask_we, clr;
    logic       int_n, vec_oe, ieo;
    logic [7:0] vec;
    logic [2:0] pending, in_service, mask;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       oe_prev = 1'b0;

    always #5 clk_sys = ~clk_sys;

    einstein_irq_ctrl dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .m1_n       (m1_n),
        .iorq_n     (iorq_n),
        .reti       (reti),
        .iei        (iei),
        .src        (src),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .clr        (clr),
        .int_n      (int_n),
        .vec        (vec),
        .vec_oe     (vec_oe),
        .ieo        (ieo),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_int_low();
        int n = 0;
        while (int_n !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        chk("int_n_asserted", 8'(int_n), 8'h00);
    endtask

    // Full acknowledge; the vector itself is checked by the monitor.
    task automatic do_ack(input logic [7:0] v, input logic [2:0] isr_exp);
        wait_int_low();
        step();
        exp_q.push_back(v);
        m1_n = 1'b0;
        iorq_n = 1'b0;
        step();
        chk("vec_oe_ack", 8'(vec_oe), 8'h01);
        chk("in_service_ack", 8'(in_service), 8'(isr_exp));
        chk("ieo_ack", 8'(ieo), 8'h00);
        step();
        chk("vec_oe_hold", 8'(vec_oe), 8'h01);
        m1_n = 1'b1;
        iorq_n = 1'b1;
        #1;
        chk("vec_oe_release", 8'(vec_oe), 8'h00);
        step();
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        step();
        reti = 1'b0;
    endtask

    // Monitor: every new vector presentation consumes one expected entry.
    always @(negedge clk_sys) begin
        if (vec_oe === 1'b1 && oe_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_vec: got %h expected none at %0t", vec, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("ack_vector", vec, mon_exp);
            end
        end
        oe_prev = vec_oe;
    end

    initial begin
        reset_n = 1'b0;
        m1_n = 1'b1; iorq_n = 1'b1; reti = 1'b0; iei = 1'b1;
        src = 3'b000; mask_we = 3'b000; mask_din = 1'b0; clr = 3'b000;
        repeat (3) step();
        chk("rst_int_n", 8'(int_n), 8'h01);
        chk("rst_vec_oe", 8'(vec_oe), 8'h00);
        chk("rst_vec", vec, 8'h00);
        chk("rst_mask", 8'(mask), 8'h07);
        chk("rst_pending", 8'(pending), 8'h00);
        chk("rst_in_service", 8'(in_service), 8'h00);
        chk("rst_ieo", 8'(ieo), 8'h01);
        reset_n = 1'b1;
        step();

        // Keyboard request, unmasked
        mask_we = 3'b001; mask_din = 1'b0;
        step();
        mask_we = 3'b000;
        chk("kb_mask", 8'(mask), 8'h06);
        src = 3'b001;
        step();
        chk("kb_pending", 8'(pending), 8'h01);
        chk("kb_int_n_not_yet", 8'(int_n), 8'h01);
        step();
        chk("kb_int_n", 8'(int_n), 8'h00);
        do_ack(8'h0E, 3'b001);
        chk("kb_pending_acked", 8'(pending), 8'h00);
        chk("kb_int_n_released", 8'(int_n), 8'h01);
        pulse_reti();
        chk("kb_reti_isr", 8'(in_service), 8'h00);
        chk("kb_reti_ieo", 8'(ieo), 8'h01);
        src = 3'b000;
        step();

        // Priority: ADC and fire together
        mask_we = 3'b110; mask_din = 1'b0;
        step();
        mask_we = 3'b000;
        src = 3'b110;
        step();
        chk("prio_pending", 8'(pending), 8'h06);
        do_ack(8'h0A, 3'b010);
        step();
        chk("prio_fire_blocked", 8'(int_n), 8'h01);
        chk("prio_fire_pending", 8'(pending), 8'h04);
        pulse_reti();
        chk("prio_reti_isr", 8'(in_service), 8'h00);
        step();
        chk("prio_int_n_again", 8'(int_n), 8'h00);
        do_ack(8'h0C, 3'b100);
        pulse_reti();
        chk("prio_reti2_isr", 8'(in_service), 8'h00);
        src = 3'b000;
        step();

        // Nesting: keyboard interrupts fire service
        src = 3'b100;
        step();
        do_ack(8'h0C, 3'b100);
        src = 3'b101;
        step();
        chk("nest_pending", 8'(pending), 8'h01);
        step();
        chk("nest_int_n", 8'(int_n), 8'h00);
        do_ack(8'h0E, 3'b101);
        pulse_reti();
        chk("nest_reti1", 8'(in_service), 8'h04);
        pulse_reti();
        chk("nest_reti2", 8'(in_service), 8'h00);
        src = 3'b000;
        step();

        // Masked source, and masking a pending source
        mask_we = 3'b010; mask_din = 1'b1;
        step();
        mask_we = 3'b000;
        chk("mask_adc", 8'(mask), 8'h02);
        src = 3'b010;
        step();
        chk("masked_pending", 8'(pending), 8'h00);
        step();
        chk("masked_int_n", 8'(int_n), 8'h01);
        src = 3'b110;
        step();
        chk("fire_pending", 8'(pending), 8'h04);
        mask_we = 3'b100; mask_din = 1'b1;
        step();
        mask_we = 3'b000;
        chk("mask_clears_pending", 8'(pending), 8'h00);
        chk("mask_fire", 8'(mask), 8'h06);
        chk("fire_int_n_brief", 8'(int_n), 8'h00);
        step();
        chk("fire_int_n_withdrawn", 8'(int_n), 8'h01);
        step();
        step();
        src = 3'b000;
        step();

        // Same-cycle clr and rise: set wins; clr alone clears
        src = 3'b001; clr = 3'b001;
        step();
        clr = 3'b000;
        chk("clr_rise_pending", 8'(pending), 8'h01);
        clr = 3'b001;
        step();
        clr = 3'b000;
        chk("clr_only_pending", 8'(pending), 8'h00);
        repeat (3) step();
        chk("clr_int_n", 8'(int_n), 8'h01);
        src = 3'b000;
        step();

        // Asynchronous reset during acknowledge
        src = 3'b001;
        step();
        chk("rstack_pending", 8'(pending), 8'h01);
        wait_int_low();
        step();
        exp_q.push_back(8'h0E);
        m1_n = 1'b0; iorq_n = 1'b0;
        step();
        chk("rstack_vec_oe", 8'(vec_oe), 8'h01);
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("rstack_vec_oe_off", 8'(vec_oe), 8'h00);
        chk("rstack_int_n", 8'(int_n), 8'h01);
        chk("rstack_mask", 8'(mask), 8'h07);
        m1_n = 1'b1; iorq_n = 1'b1; src = 3'b000;
        step();
        reset_n = 1'b1;
        step();

        // intack with iei=0, then intack in IDLE
        mask_we = 3'b001; mask_din = 1'b0;
        step();
        mask_we = 3'b000;
        iei = 1'b0;
        src = 3'b001;
        step();
        chk("iei0_pending", 8'(pending), 8'h01);
        step();
        chk("iei0_int_n", 8'(int_n), 8'h01);
        chk("iei0_ieo", 8'(ieo), 8'h00);
        m1_n = 1'b0; iorq_n = 1'b0;
        step();
        chk("iei0_vec_oe", 8'(vec_oe), 8'h00);
        step();
        chk("iei0_vec_oe2", 8'(vec_oe), 8'h00);
        m1_n = 1'b1; iorq_n = 1'b1; clr = 3'b001;
        step();
        clr = 3'b000; iei = 1'b1; src = 3'b000;
        step();
        chk("idle_pending", 8'(pending), 8'h00);
        m1_n = 1'b0; iorq_n = 1'b0;
        step();
        chk("idle_vec_oe", 8'(vec_oe), 8'h00);
        step();
        chk("idle_vec_oe2", 8'(vec_oe), 8'h00);
        m1_n = 1'b1; iorq_n = 1'b1;
        step();
        chk("idle_int_n", 8'(int_n), 8'h01);
        chk("idle_ieo", 8'(ieo), 8'h01);

        step();
        chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
